// File: rtl/lap_stopwatch.sv
`timescale 1ns/1ps
// lap_stopwatch: sub-second/second/minute/hour stopwatch advanced by an
// external tick, with start/stop, clear and a show-ahead lap FIFO.
// LAP_DEPTH must be a power of two and at least 2 so the pointers wrap
// naturally and a full FIFO always holds a second entry behind the head.
module lap_stopwatch #(
  parameter  int unsigned SUBSEC_MAX = 99,
  parameter  int unsigned HOUR_MAX   = 99,
  parameter  int unsigned LAP_DEPTH  = 4,
  localparam int unsigned SUB_W      = $clog2(SUBSEC_MAX + 1),
  localparam int unsigned HOUR_W     = $clog2(HOUR_MAX + 1),
  localparam int unsigned LAP_W      = HOUR_W + 12 + SUB_W,
  localparam int unsigned CNT_W      = $clog2(LAP_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              start_stop,
  input  logic              clear,
  input  logic              lap,
  input  logic              lap_rd,
  output logic              running,
  output logic [SUB_W-1:0]  sub,
  output logic [5:0]        sec,
  output logic [5:0]        min,
  output logic [HOUR_W-1:0] hour,
  output logic              lap_valid,
  output logic [LAP_W-1:0]  lap_data,
  output logic [CNT_W-1:0]  lap_count,
  output logic              lap_full,
  output logic              lap_drop,
  output logic              ovf
);

  localparam int unsigned PTR_W = $clog2(LAP_DEPTH);

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } state_e;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [5:0]        min;
    logic [5:0]        sec;
    logic [SUB_W-1:0]  sub;
  } lap_entry_t;

  state_e            state_q, state_d;

  logic [SUB_W-1:0]  sub_q, sub_d;
  logic [5:0]        sec_q, sec_d;
  logic [5:0]        min_q, min_d;
  logic [HOUR_W-1:0] hour_q, hour_d;
  logic              ovf_q, ovf_d;

  lap_entry_t        mem_q [LAP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  rd_next;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              full_q, full_d;
  logic              drop_q, drop_d;
  lap_entry_t        lap_data_q, lap_data_d;
  lap_entry_t        new_entry;

  // Per-cycle decisions, all made on the pre-edge running state
  logic do_clear;
  logic do_tick;
  logic push_req;
  logic pop;
  logic push;

  // Running-state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_STOPPED;
    end else begin
      state_q <= state_d;
    end
  end

  // Running-state next state and the qualified clear/tick/lap strobes
  always_comb begin
    state_d  = state_q;
    do_clear = 1'b0;
    do_tick  = 1'b0;
    push_req = 1'b0;
    case (state_q)
      ST_STOPPED: begin
        do_clear = clear;
        if (start_stop) state_d = ST_RUNNING;
      end
      ST_RUNNING: begin
        do_tick  = tick;
        push_req = lap;
        if (start_stop) state_d = ST_STOPPED;
      end
      default: state_d = ST_STOPPED;
    endcase
  end

  // Time counter chain with full-scale wrap detection
  always_comb begin
    sub_d  = sub_q;
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    ovf_d  = ovf_q;
    if (do_clear) begin
      sub_d  = '0;
      sec_d  = '0;
      min_d  = '0;
      hour_d = '0;
      ovf_d  = 1'b0;
    end else if (do_tick) begin
      if (sub_q == SUB_W'(SUBSEC_MAX)) begin
        sub_d = '0;
        if (sec_q == 6'd59) begin
          sec_d = '0;
          if (min_q == 6'd59) begin
            min_d = '0;
            if (hour_q == HOUR_W'(HOUR_MAX)) begin
              hour_d = '0;
              ovf_d  = 1'b1;
            end else begin
              hour_d = hour_q + HOUR_W'(1);
            end
          end else begin
            min_d = min_q + 6'd1;
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else begin
        sub_d = sub_q + SUB_W'(1);
      end
    end
  end

  // Lap FIFO control: pointers, occupancy, drop flag and the head register
  always_comb begin
    new_entry      = '0;
    new_entry.hour = hour_q;
    new_entry.min  = min_q;
    new_entry.sec  = sec_q;
    new_entry.sub  = sub_q;

    pop      = lap_rd && valid_q;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    push     = push_req && (!full_q || pop);
    rd_next  = rd_ptr_q + PTR_W'(1);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    drop_d   = drop_q;

    if (do_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      drop_d   = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_next;
      if (push && !pop) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else if (pop && !push) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
      if (push_req && full_q && !pop) drop_d = 1'b1;
    end

    valid_d = (cnt_d != '0);
    full_d  = (cnt_d == CNT_W'(LAP_DEPTH));

    // Head entry for the next cycle, never sourced from an unwritten slot
    if (cnt_d == '0) begin
      lap_data_d = '0;
    end else if (pop) begin
      lap_data_d = (cnt_q > CNT_W'(1)) ? mem_q[rd_next] : new_entry;
    end else if (cnt_q == '0) begin
      lap_data_d = new_entry;
    end else begin
      lap_data_d = lap_data_q;
    end
  end

  // Counter, flag and FIFO control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_q      <= '0;
      sec_q      <= '0;
      min_q      <= '0;
      hour_q     <= '0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      full_q     <= 1'b0;
      drop_q     <= 1'b0;
      lap_data_q <= '0;
    end else begin
      sub_q      <= sub_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      full_q     <= full_d;
      drop_q     <= drop_d;
      lap_data_q <= lap_data_d;
    end
  end

  // Lap storage; contents are only ever read behind a valid occupancy count
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= new_entry;
  end

  assign running   = (state_q == ST_RUNNING);
  assign sub       = sub_q;
  assign sec       = sec_q;
  assign min       = min_q;
  assign hour      = hour_q;
  assign ovf       = ovf_q;
  assign lap_valid = valid_q;
  assign lap_full  = full_q;
  assign lap_count = cnt_q;
  assign lap_drop  = drop_q;
  assign lap_data  = lap_data_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
`timescale 1ns/1ps
// Scoreboard bench for lap_stopwatch: a driver applies directed and random
// pulses, an elapsed-tick model predicts outputs, a monitor compares them.
module tb_lap_stopwatch;

  localparam int unsigned SUBSEC_MAX = 99;
  localparam int unsigned HOUR_MAX   = 99;
  localparam int unsigned LAP_DEPTH  = 4;
  localparam int unsigned SUB_W      = $clog2(SUBSEC_MAX + 1);
  localparam int unsigned HOUR_W     = $clog2(HOUR_MAX + 1);
  localparam int unsigned LAP_W      = HOUR_W + 12 + SUB_W;
  localparam int unsigned CNT_W      = $clog2(LAP_DEPTH) + 1;
  localparam int          TPS        = SUBSEC_MAX + 1;
  localparam int          TOTAL      = TPS * 3600 * (HOUR_MAX + 1);

  // Small instance so that full-scale wrap is reachable in simulation
  localparam int unsigned S_SUBSEC_MAX = 1;
  localparam int unsigned S_HOUR_MAX   = 1;
  localparam int unsigned S_SUB_W      = $clog2(S_SUBSEC_MAX + 1);
  localparam int unsigned S_HOUR_W     = $clog2(S_HOUR_MAX + 1);
  localparam int unsigned S_LAP_W      = S_HOUR_W + 12 + S_SUB_W;
  localparam int unsigned S_CNT_W      = $clog2(LAP_DEPTH) + 1;
  localparam int          S_TOTAL      = (S_SUBSEC_MAX + 1) * 3600 * (S_HOUR_MAX + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0, start_stop = 1'b0, clear = 1'b0, lap = 1'b0, lap_rd = 1'b0;
  logic              running;
  logic [SUB_W-1:0]  sub;
  logic [5:0]        sec, min;
  logic [HOUR_W-1:0] hour;
  logic              lap_valid, lap_full, lap_drop, ovf;
  logic [LAP_W-1:0]  lap_data;
  logic [CNT_W-1:0]  lap_count;

  logic s_tick = 1'b0, s_ss = 1'b0, s_clear = 1'b0, s_lap = 1'b0, s_lap_rd = 1'b0;
  logic                s_running;
  logic [S_SUB_W-1:0]  s_sub;
  logic [5:0]          s_sec, s_min;
  logic [S_HOUR_W-1:0] s_hour;
  logic                s_lap_valid, s_lap_full, s_lap_drop, s_ovf;
  logic [S_LAP_W-1:0]  s_lap_data;
  logic [S_CNT_W-1:0]  s_lap_count;

  always #5 clk = ~clk;

  lap_stopwatch #(.SUBSEC_MAX(SUBSEC_MAX), .HOUR_MAX(HOUR_MAX), .LAP_DEPTH(LAP_DEPTH)) u_dut (
    .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .clear(clear),
    .lap(lap), .lap_rd(lap_rd), .running(running), .sub(sub), .sec(sec),
    .min(min), .hour(hour), .lap_valid(lap_valid), .lap_data(lap_data),
    .lap_count(lap_count), .lap_full(lap_full), .lap_drop(lap_drop), .ovf(ovf)
  );

  lap_stopwatch #(.SUBSEC_MAX(S_SUBSEC_MAX), .HOUR_MAX(S_HOUR_MAX), .LAP_DEPTH(LAP_DEPTH)) u_small (
    .clk(clk), .rst(rst), .tick(s_tick), .start_stop(s_ss), .clear(s_clear),
    .lap(s_lap), .lap_rd(s_lap_rd), .running(s_running), .sub(s_sub), .sec(s_sec),
    .min(s_min), .hour(s_hour), .lap_valid(s_lap_valid), .lap_data(s_lap_data),
    .lap_count(s_lap_count), .lap_full(s_lap_full), .lap_drop(s_lap_drop), .ovf(s_ovf)
  );

  typedef struct {
    bit          run;
    int          t;
    int          cnt;
    logic [63:0] front;
    bit          drop;
    bit          ovf;
    bit          after_rst;
  } snap_t;

  int errors = 0;
  int checks = 0;

  // Reference model: elapsed ticks as one integer plus a queue of laps
  int          m_t    = 0;
  bit          m_run  = 1'b0;
  bit          m_drop = 1'b0;
  bit          m_ovf  = 1'b0;
  logic [63:0] m_laps [$];
  snap_t       exp_q  [$];
  logic [63:0] rd_q   [$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, expv, $time);
    end
  endtask

  function automatic logic [63:0] pack_t(input int t);
    int su, se, mi, ho;
    su = t % TPS;
    se = (t / TPS) % 60;
    mi = (t / (TPS * 60)) % 60;
    ho = t / (TPS * 3600);
    return (64'(ho) << (12 + SUB_W)) | (64'(mi) << (6 + SUB_W)) | (64'(se) << SUB_W) | 64'(su);
  endfunction

  function automatic void model_reset();
    m_t = 0; m_run = 1'b0; m_drop = 1'b0; m_ovf = 1'b0;
    m_laps.delete();
    rd_q.delete();
  endfunction

  function automatic void push_snap(input bit ar);
    snap_t e;
    e.run = m_run; e.t = m_t; e.cnt = m_laps.size();
    e.front = (m_laps.size() > 0) ? m_laps[0] : 64'd0;
    e.drop = m_drop; e.ovf = m_ovf; e.after_rst = ar;
    exp_q.push_back(e);
  endfunction

  function automatic void model_step(input bit t, input bit ss, input bit cl, input bit lp, input bit rd);
    bit          was_run;
    logic [63:0] snap;
    was_run = m_run;
    snap    = pack_t(m_t);
    if (ss) m_run = !m_run;
    if (!was_run && cl) begin
      m_t = 0; m_laps.delete(); m_drop = 1'b0; m_ovf = 1'b0;
    end
    if (rd && m_laps.size() > 0) void'(m_laps.pop_front());
    if (was_run && lp) begin
      if (m_laps.size() >= LAP_DEPTH) m_drop = 1'b1;
      else m_laps.push_back(snap);
    end
    if (was_run && t) begin
      m_t++;
      if (m_t == TOTAL) begin
        m_t = 0; m_ovf = 1'b1;
      end
    end
  endfunction

  // One clock of stimulus; entered and left just after a rising edge
  task automatic cyc(input bit t, input bit ss, input bit cl, input bit lp, input bit rd);
    tick = t; start_stop = ss; clear = cl; lap = lp; lap_rd = rd;
    if (rd && m_laps.size() > 0) rd_q.push_back(m_laps[0]);
    @(posedge clk);
    model_step(t, ss, cl, lp, rd);
    push_snap(1'b0);
    #1;
    tick = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0; lap_rd = 1'b0;
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 20000 && m_t < target; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("run_to_reached", 64'(m_t), 64'(target));
  endtask

  task automatic stop_if_running();
    if (m_run) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_running", 64'(running), 64'd0);
    check("arst_time", 64'({hour, min, sec, sub}), 64'd0);
    check("arst_lap_valid", 64'(lap_valid), 64'd0);
    check("arst_lap_count", 64'(lap_count), 64'd0);
    check("arst_lap_data", 64'(lap_data), 64'd0);
    check("arst_flags", 64'({lap_full, lap_drop, ovf}), 64'd0);
    @(posedge clk);
    model_reset();
    push_snap(1'b1);
    #1 rst = 1'b0;
  endtask

  task automatic small_wrap();
    s_ss = 1'b1;
    @(posedge clk); #1 s_ss = 1'b0;
    s_tick = 1'b1;
    repeat (S_TOTAL - 1) @(posedge clk);
    #1 s_tick = 1'b0;
    check("small_at_max", 64'({s_hour, s_min, s_sec, s_sub}),
          64'({1'b1, 6'd59, 6'd59, 1'b1}));
    check("small_ovf_before_wrap", 64'(s_ovf), 64'd0);
    s_tick = 1'b1;
    @(posedge clk); #1 s_tick = 1'b0;
    check("small_wrap_time", 64'({s_hour, s_min, s_sec, s_sub}), 64'd0);
    check("small_wrap_ovf", 64'(s_ovf), 64'd1);
    s_clear = 1'b1;
    @(posedge clk); #1 s_clear = 1'b0;
    check("small_clear_running_ovf", 64'(s_ovf), 64'd1);
    check("small_clear_running_run", 64'(s_running), 64'd1);
    s_ss = 1'b1;
    @(posedge clk); #1 s_ss = 1'b0;
    check("small_stopped", 64'(s_running), 64'd0);
    s_clear = 1'b1;
    @(posedge clk); #1 s_clear = 1'b0;
    check("small_clear_ovf", 64'(s_ovf), 64'd0);
    check("small_clear_time", 64'({s_hour, s_min, s_sec, s_sub}), 64'd0);
  endtask

  // Monitor: compares the predicted state and any lap entry being read out
  initial begin
    snap_t       e;
    logic [63:0] r;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("running", 64'(running), 64'(e.run));
        check("time", 64'({hour, min, sec, sub}), pack_t(e.t));
        check("lap_count", 64'(lap_count), 64'(e.cnt));
        check("lap_valid", 64'(lap_valid), 64'(e.cnt > 0));
        check("lap_full", 64'(lap_full), 64'(e.cnt == LAP_DEPTH));
        if (e.cnt > 0 || e.after_rst) check("lap_data", 64'(lap_data), e.front);
        check("lap_drop", 64'(lap_drop), 64'(e.drop));
        check("ovf", 64'(ovf), 64'(e.ovf));
      end
      if (lap_rd) begin
        if (rd_q.size() > 0) begin
          r = rd_q.pop_front();
          check("read_valid", 64'(lap_valid), 64'd1);
          check("read_data", 64'(lap_data), r);
        end else begin
          check("read_on_empty_valid", 64'(lap_valid), 64'd0);
        end
      end
    end
  end

  // Driver
  initial begin
    @(posedge clk);
    model_reset();
    push_snap(1'b1);
    #1 rst = 1'b0;

    // Start and count one second
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_to(100);

    // Four laps then a dropped fifth
    run_to(150); cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_to(300); cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_to(725); cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_to(999); cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Push and pop together while full, then drain and pop an empty FIFO
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Clear together with start, then lap coinciding with a tick
    stop_if_running();
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    run_to(41);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Random pulses
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 3,
          $urandom_range(0, 99) < 4,  $urandom_range(0, 99) < 15,
          $urandom_range(0, 99) < 20);
    end

    // Asynchronous reset with three laps held
    stop_if_running();
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      repeat (7) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    async_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    small_wrap();

    @(negedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size() + rd_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
